timer_counter: RTL
==================

Name: timer_counter

Overview:
- Parametrised successor to the team's single-mode go/en up-counter.
- Counts up or down between 0 and a runtime-programmable limit.
- Supports one-shot mode (halts at the terminal value) and auto-reload mode (restarts and tallies wraps).
- Serves as the generic timing/score/tempo source for the game logic; a one-cycle done pulse feeds downstream FSMs.

Parameters:
WIDTH, 13, width of count and limit.
WRAPW, 8, width of the saturating wrap tally.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
go  input  1  start/restart; samples limit, down, reload.
en  input  1  count enable; count holds when low.
stop  input  1  abort to IDLE; count frozen.
limit  input  WIDTH  terminal value (up) / start value (down).
down  input  1  direction: 0 = up from 0 to limit, 1 = down from limit to 0.
reload  input  1  1 = auto-reload, 0 = one-shot.
count  output  WIDTH  current count.
busy  output  1  high in RUN.
expired  output  1  high in HOLD (one-shot finished).
done  output  1  one-cycle pulse when the terminal value is consumed.
wraps  output  WRAPW  reload count since last go, saturating.

Behaviour:
- Reset (async, any time): count=0, state=IDLE, busy=0, expired=0, done=0, wraps=0. Internal lim_q, dir_q and rel_q reset to 0.
- States: IDLE (00), RUN (01), HOLD (10). Code 11 is illegal and goes to IDLE next clock. busy and expired are decoded directly from state.
- Priority per edge: reset > go > stop > counting.
- go (any state):
  - lim_q<=limit, dir_q<=down, rel_q<=reload.
  - count <= down ? limit : 0.
  - wraps<=0, done<=0, state<=RUN.
  - go held high keeps reloading, so no counting occurs.
- stop (go low, any state): state<=IDLE, count unchanged, done<=0.
- start value S = dir_q ? lim_q : 0. Terminal T = dir_q ? 0 : lim_q.
- RUN, en=0: count, wraps and state hold; done=0.
- RUN, en=1, count!=T: count<=count+1 (up) or count-1 (down), modulo 2^WIDTH. No intermediate overflow is possible since count stays within [0, lim_q].
- RUN, en=1, count==T: done<=1 for exactly this edge's next cycle.
  - rel_q=1: count<=S, wraps<=wraps+1 saturating at all-ones, stay RUN.
  - rel_q=0: count holds T, state<=HOLD.
- Terminal latency: with en held high from the go edge (edge 0), count first equals T after lim_q edges, and done is high in the cycle after edge lim_q+1.
  - In auto-reload the period is lim_q+1 cycles.
- lim_q=0: count==T immediately. done pulses after edge 1 and every subsequent edge in reload mode (period 1, done stays high continuously).
- limit/down/reload changes while not sampled by go have no effect.
- IDLE and HOLD: count holds, done=0; only go leaves them.
- Full range: limit=2^WIDTH-1 is legal and must count to all-ones without wrap to 0 before done.

Test Plan:
- Reset mid-RUN: reset asserted asynchronously between edges at count=37 -> count=0, busy=0, expired=0 before the next edge; outputs held while reset high.
- One-shot up: limit=5, down=0, reload=0, go one cycle, en=1 -> count 0,1,2,3,4,5, done pulses one cycle as state enters HOLD; expired=1, count stays 5 for 10 further cycles.
- Down auto-reload: limit=3, down=1, reload=1, en=1 -> count 3,2,1,0,3,2,1,0...; done once per 4 cycles; wraps=2 after two reloads. With WRAPW=2 and 5 reloads, wraps saturates at 3.
- Enable gating and stop: limit=10 up, en toggled 1/0 every cycle -> count advances every other cycle, done after 21 cycles. stop at count=4 -> IDLE, count held 4, no done; go restarts at 0.
- Go priority and retrigger: go and stop asserted together in HOLD -> RUN from S. go asserted mid-RUN at count=7 with new limit=2 -> count restarts at 0, done after reaching 2, wraps cleared.
- Edge limits: limit=0 reload=1 -> done high every cycle, count stays 0. WIDTH=4, limit=15 up one-shot -> count reaches 15, no wrap to 0, done once.

Source files
------------

// File: rtl/timer_counter.sv
// Up/down timer with one-shot and auto-reload modes, a one-cycle done pulse
// and a saturating tally of reloads since the last go.
module timer_counter #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned WRAPW = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_go,
    input  logic             i_en,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_down,
    input  logic             i_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_expired,
    output logic             o_done,
    output logic [WRAPW-1:0] o_wraps
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nxt;
    logic [WIDTH-1:0]   r_lim;
    logic [WIDTH-1:0]   w_lim_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic               r_rel;
    logic               w_rel_nxt;
    logic [WRAPW-1:0]   r_wraps;
    logic [WRAPW-1:0]   w_wraps_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_start;
    logic [WIDTH-1:0]   w_term;

    assign w_start = r_dir ? r_lim : '0;
    assign w_term  = r_dir ? '0 : r_lim;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_count <= '0;
            r_lim   <= '0;
            r_dir   <= 1'b0;
            r_rel   <= 1'b0;
            r_wraps <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_lim   <= w_lim_nxt;
            r_dir   <= w_dir_nxt;
            r_rel   <= w_rel_nxt;
            r_wraps <= w_wraps_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_lim_nxt   = r_lim;
        w_dir_nxt   = r_dir;
        w_rel_nxt   = r_rel;
        w_wraps_nxt = r_wraps;
        w_done_nxt  = 1'b0;

        if (i_go) begin
            w_lim_nxt   = i_limit;
            w_dir_nxt   = i_down;
            w_rel_nxt   = i_reload;
            w_count_nxt = i_down ? i_limit : '0;
            w_wraps_nxt = '0;
            w_state_nxt = StRun;
        end else if (i_stop) begin
            w_state_nxt = StIdle;
        end else begin
            case (r_state)
                StIdle, StHold: ;
                StRun: begin
                    if (i_en) begin
                        if (r_count == w_term) begin
                            // Terminal value consumed: pulse done, then reload or park.
                            w_done_nxt = 1'b1;
                            if (r_rel) begin
                                w_count_nxt = w_start;
                                if (r_wraps != '1) begin
                                    w_wraps_nxt = r_wraps + WRAPW'(1);
                                end
                            end else begin
                                w_state_nxt = StHold;
                            end
                        end else if (r_dir) begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end else begin
                            w_count_nxt = r_count + WIDTH'(1);
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    assign o_count   = r_count;
    assign o_busy    = (r_state == StRun);
    assign o_expired = (r_state == StHold);
    assign o_done    = r_done;
    assign o_wraps   = r_wraps;

endmodule
